// File: rtl/core_seq.sv
// rtl/core_seq.sv - multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB over one unified memory port
// Optional: `CORE_SEQ_TIMEOUT_EN adds a per-access mem_ready watchdog with sticky bus_err.
`ifndef RDSRC_MEM
`define RDSRC_MEM 2'd1
`endif

module core_seq #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             cu_pc_write,
  input  logic             cu_rd_write,
  input  logic [1:0]       cu_rd_write_src,
  input  logic             cu_mem_write,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_load,
  output logic             mdr_load,
  output logic             pc_en,
  output logic             rd_en,
  output logic             busy,
  output logic [CNT_W-1:0] instret,
  output logic             bus_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5
  } state_t;

  state_t state, state_nxt;
  logic   is_load;
  logic   mem_op;
  logic   timeout;

  // cu_pc_write only steers next-PC selection in the datapath
  logic   unused_pc_write;
  assign unused_pc_write = cu_pc_write;

  assign is_load = (cu_rd_write_src == `RDSRC_MEM);
  assign mem_op  = cu_mem_write | is_load;

`ifdef CORE_SEQ_TIMEOUT_EN
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  logic [WAIT_W-1:0] wait_cnt;
  logic              in_access;
  logic              bus_err_q;

  assign in_access = (state == FETCH) || (state == MEM);
  assign timeout   = in_access && !mem_ready && (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));
  assign bus_err   = bus_err_q;

  // Counter is cleared outside an access, so it restarts on every FETCH/MEM entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt  <= '0;
      bus_err_q <= 1'b0;
    end else begin
      if (!in_access || mem_ready || timeout)
        wait_cnt <= '0;
      else
        wait_cnt <= wait_cnt + WAIT_W'(1);
      if (timeout)
        bus_err_q <= 1'b1;
    end
  end
`else
  localparam int UNUSED_MEM_TIMEOUT = MEM_TIMEOUT;

  assign timeout = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (run && !bus_err) state_nxt = FETCH;
      FETCH: begin
        if (mem_ready)    state_nxt = DECODE;
        else if (timeout) state_nxt = IDLE;
      end
      DECODE:  state_nxt = EXEC;
      EXEC:    state_nxt = mem_op ? MEM : WB;
      MEM: begin
        if (mem_ready)    state_nxt = WB;
        else if (timeout) state_nxt = IDLE;
      end
      WB:      state_nxt = run ? FETCH : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Decoder enables are gated so each only reaches the datapath in its own stage
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_load      = 1'b0;
    mdr_load     = 1'b0;
    pc_en        = 1'b0;
    rd_en        = 1'b0;
    case (state)
      FETCH: begin
        mem_req = 1'b1;
        ir_load = mem_ready;
      end
      MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = cu_mem_write;
        mdr_load     = mem_ready & is_load & ~cu_mem_write;
      end
      WB: begin
        pc_en = 1'b1;
        rd_en = cu_rd_write;
      end
      default: ;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      instret <= '0;
    else if (state == WB)
      instret <= instret + CNT_W'(1);
  end

endmodule

// File: tb/tb_core_seq.sv
// tb/tb_core_seq.sv - scoreboard bench for core_seq (CNT_W=4, MEM_TIMEOUT=8)
`timescale 1ns/1ps
`ifndef RDSRC_MEM
`define RDSRC_MEM 2'd1
`endif

module tb_core_seq;
  localparam int CNT_W       = 4;
  localparam int MEM_TIMEOUT = 8;

  // per-cycle trace vector: {busy, mem_req, mem_we, mem_addr_sel, ir_load, mdr_load, pc_en, rd_en}
  localparam logic [7:0] V_IDLE = 8'b0000_0000;
  localparam logic [7:0] V_FZ   = 8'b1100_1000;
  localparam logic [7:0] V_FW   = 8'b1100_0000;
  localparam logic [7:0] V_DEC  = 8'b1000_0000;
  localparam logic [7:0] V_LW   = 8'b1101_0000;
  localparam logic [7:0] V_LR   = 8'b1101_0100;
  localparam logic [7:0] V_ST   = 8'b1111_0000;
  localparam logic [7:0] V_WBR  = 8'b1000_0011;
  localparam logic [7:0] V_WBN  = 8'b1000_0010;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             run = 1'b0;
  logic             cu_pc_write = 1'b0;
  logic             cu_rd_write = 1'b0;
  logic [1:0]       cu_rd_write_src = 2'd0;
  logic             cu_mem_write = 1'b0;
  logic             mem_ready = 1'b0;
  logic             mem_req, mem_we, mem_addr_sel, ir_load, mdr_load, pc_en, rd_en, busy, bus_err;
  logic [CNT_W-1:0] instret;

  core_seq #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .cu_pc_write(cu_pc_write),
    .cu_rd_write(cu_rd_write), .cu_rd_write_src(cu_rd_write_src),
    .cu_mem_write(cu_mem_write), .mem_ready(mem_ready), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_load(ir_load),
    .mdr_load(mdr_load), .pc_en(pc_en), .rd_en(rd_en), .busy(busy),
    .instret(instret), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int               n_cmp = 0;
  int               n_err = 0;
  logic [CNT_W-1:0] exp_cnt = '0;
  int               fetch_wait = 0;
  int               mem_wait = 0;
  int               wcnt = 0;
  bit               spurious = 1'b0;
  bit               mon_en = 1'b0;
  logic [7:0]       exp_q[$];
  logic [7:0]       obs_q[$];

  // memory responder: mem_ready after a programmed number of wait cycles
  always @(negedge clk) begin
    if (!mem_req) begin
      mem_ready = spurious;
      wcnt = 0;
    end else if (wcnt >= (mem_addr_sel ? mem_wait : fetch_wait)) begin
      mem_ready = 1'b1;
      wcnt = 0;
    end else begin
      mem_ready = 1'b0;
      wcnt++;
    end
  end

  always @(negedge clk) begin
    #2;
    if (mon_en)
      obs_q.push_back({busy, mem_req, mem_we, mem_addr_sel, ir_load, mdr_load, pc_en, rd_en});
  end

  task automatic issue(input logic rdw, input logic [1:0] src, input logic mw,
                       input int fw, input int mwt, input int run_cyc);
    @(negedge clk);
    cu_rd_write = rdw;
    cu_rd_write_src = src;
    cu_mem_write = mw;
    cu_pc_write = ~rdw & ~mw;
    fetch_wait = fw;
    mem_wait = mwt;
    run = 1'b1;
    @(posedge clk);
    #1 mon_en = 1'b1;
    for (int i = 1; i < run_cyc; i++) @(posedge clk);
    #1 run = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #3;
      if (!busy) break;
    end
    mon_en = 1'b0;
    if (busy) begin
      n_cmp++;
      n_err++;
      $display("FAIL issue_bound: busy=%b required 0 within 60 cycles", busy);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    #3;
    n_cmp++;
    if ({busy, mem_req, mem_we, mem_addr_sel, ir_load, mdr_load, pc_en, rd_en, bus_err} !== 9'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b required 000000000",
               {busy, mem_req, mem_we, mem_addr_sel, ir_load, mdr_load, pc_en, rd_en, bus_err});
    end
    n_cmp++;
    if (instret !== '0) begin
      n_err++;
      $display("FAIL reset_instret: got %0d required 0", instret);
    end
    rst_n = 1'b1;
    @(negedge clk);
    fetch_wait = 1000;
    run = 1'b1;
    @(posedge clk);
    #1 run = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    n_cmp++;
    if (mem_req !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_req_before: got %b required 1", mem_req);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({mem_req, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_mid_drop: got {mem_req,busy}=%b required 00", {mem_req, busy});
    end
    @(negedge clk);
    rst_n = 1'b1;
    fetch_wait = 0;
    exp_cnt = '0;
  endtask

  task automatic test_alu;
    exp_q.push_back(V_FZ); exp_q.push_back(V_DEC); exp_q.push_back(V_DEC);
    exp_q.push_back(V_WBR); exp_q.push_back(V_IDLE);
    issue(1'b1, 2'd0, 1'b0, 0, 0, 1);
    exp_cnt++;
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL alu_len: got %0d cycles required %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; exp_q.size() > 0 && obs_q.size() > 0; k++) begin
      logic [7:0] e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL alu_trace[%0d]: got %b required %b", k, o, e);
      end
    end
    exp_q.delete(); obs_q.delete();
    n_cmp++;
    if (instret !== exp_cnt) begin
      n_err++;
      $display("FAIL alu_instret: got %0d required %0d", instret, exp_cnt);
    end
  endtask

  task automatic test_load;
    exp_q.push_back(V_FZ); exp_q.push_back(V_DEC); exp_q.push_back(V_DEC);
    repeat (3) exp_q.push_back(V_LW);
    exp_q.push_back(V_LR); exp_q.push_back(V_WBR); exp_q.push_back(V_IDLE);
    issue(1'b1, `RDSRC_MEM, 1'b0, 0, 3, 1);
    exp_cnt++;
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL load_len: got %0d cycles required %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; exp_q.size() > 0 && obs_q.size() > 0; k++) begin
      logic [7:0] e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL load_trace[%0d]: got %b required %b", k, o, e);
      end
    end
    exp_q.delete(); obs_q.delete();
    n_cmp++;
    if (instret !== exp_cnt) begin
      n_err++;
      $display("FAIL load_instret: got %0d required %0d", instret, exp_cnt);
    end
  endtask

  task automatic test_store;
    exp_q.push_back(V_FZ); exp_q.push_back(V_DEC); exp_q.push_back(V_DEC);
    exp_q.push_back(V_ST); exp_q.push_back(V_WBN); exp_q.push_back(V_IDLE);
    issue(1'b0, 2'd0, 1'b1, 0, 0, 1);
    exp_cnt++;
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL store_len: got %0d cycles required %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; exp_q.size() > 0 && obs_q.size() > 0; k++) begin
      logic [7:0] e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL store_trace[%0d]: got %b required %b", k, o, e);
      end
    end
    exp_q.delete(); obs_q.delete();
    n_cmp++;
    if (instret !== exp_cnt) begin
      n_err++;
      $display("FAIL store_instret: got %0d required %0d", instret, exp_cnt);
    end
  endtask

  task automatic test_run_stop;
    exp_q.push_back(V_FZ); exp_q.push_back(V_DEC); exp_q.push_back(V_DEC);
    exp_q.push_back(V_WBN); exp_q.push_back(V_IDLE);
    issue(1'b0, 2'd0, 1'b0, 0, 0, 3);
    exp_cnt++;
    exp_q.push_back(V_FW); exp_q.push_back(V_FW); exp_q.push_back(V_FZ);
    exp_q.push_back(V_DEC); exp_q.push_back(V_DEC); exp_q.push_back(V_WBR);
    exp_q.push_back(V_IDLE);
    issue(1'b1, 2'd0, 1'b0, 2, 0, 1);
    exp_cnt++;
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL runstop_len: got %0d cycles required %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; exp_q.size() > 0 && obs_q.size() > 0; k++) begin
      logic [7:0] e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL runstop_trace[%0d]: got %b required %b", k, o, e);
      end
    end
    exp_q.delete(); obs_q.delete();
    n_cmp++;
    if (instret !== exp_cnt) begin
      n_err++;
      $display("FAIL runstop_instret: got %0d required %0d", instret, exp_cnt);
    end
  endtask

  task automatic test_back_to_back;
    spurious = 1'b1;
    for (int j = 0; j < 2; j++) begin
      exp_q.push_back(V_FZ); exp_q.push_back(V_DEC); exp_q.push_back(V_DEC);
      exp_q.push_back(V_WBR);
    end
    exp_q.push_back(V_IDLE);
    issue(1'b1, 2'd0, 1'b0, 0, 0, 5);
    exp_cnt += 2;
    spurious = 1'b0;
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL b2b_len: got %0d cycles required %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; exp_q.size() > 0 && obs_q.size() > 0; k++) begin
      logic [7:0] e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL b2b_trace[%0d]: got %b required %b", k, o, e);
      end
    end
    exp_q.delete(); obs_q.delete();
    n_cmp++;
    if (instret !== exp_cnt) begin
      n_err++;
      $display("FAIL b2b_instret: got %0d required %0d", instret, exp_cnt);
    end
  endtask

  task automatic test_wrap;
    while (exp_cnt != {CNT_W{1'b1}}) begin
      issue(1'b0, 2'd0, 1'b0, 0, 0, 1);
      exp_cnt++;
      obs_q.delete();
    end
    n_cmp++;
    if (instret !== exp_cnt) begin
      n_err++;
      $display("FAIL wrap_allones: got %0d required %0d", instret, exp_cnt);
    end
    issue(1'b1, 2'd0, 1'b0, 0, 0, 1);
    exp_cnt++;
    obs_q.delete();
    n_cmp++;
    if (instret !== exp_cnt) begin
      n_err++;
      $display("FAIL wrap_zero: got %0d required %0d", instret, exp_cnt);
    end
  endtask

`ifdef CORE_SEQ_TIMEOUT_EN
  task automatic test_timeout;
    repeat (MEM_TIMEOUT) exp_q.push_back(V_FW);
    exp_q.push_back(V_IDLE);
    issue(1'b1, 2'd0, 1'b0, 1000, 0, 1);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL timeout_len: got %0d cycles required %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; exp_q.size() > 0 && obs_q.size() > 0; k++) begin
      logic [7:0] e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL timeout_trace[%0d]: got %b required %b", k, o, e);
      end
    end
    exp_q.delete(); obs_q.delete();
    n_cmp++;
    if ({bus_err, instret} !== {1'b1, exp_cnt}) begin
      n_err++;
      $display("FAIL timeout_flag: got bus_err=%b instret=%0d required 1 and %0d", bus_err, instret, exp_cnt);
    end
    @(negedge clk);
    run = 1'b1;
    repeat (5) @(negedge clk);
    #3;
    n_cmp++;
    if ({busy, mem_req, bus_err} !== 3'b001) begin
      n_err++;
      $display("FAIL timeout_stuck: got {busy,mem_req,bus_err}=%b required 001", {busy, mem_req, bus_err});
    end
    run = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus_err !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_clear: got %b required 0", bus_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    fetch_wait = 0;
    exp_cnt = '0;
  endtask
`endif

  initial begin
    test_reset;
    test_alu;
    test_load;
    test_store;
    test_run_stop;
    test_back_to_back;
    test_wrap;
`ifdef CORE_SEQ_TIMEOUT_EN
    test_timeout;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_bound: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
